// File: rtl/comp_cal_pkg.sv
// comp_cal_pkg: shared types and width helpers for the comparator offset-calibration block.
//
// Contents:
//   cal_state_e  - calibration controller states
//   cal_dir_e    - direction of the last trim step (none / up / down)
//   trim_width() - width of the signed trim code for a given number of unit caps per side
//   cnt_width()  - width of a counter that must hold the value n without wrapping
package comp_cal_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StDecide,
        StFinish
    } cal_state_e;

    typedef enum logic [1:0] {
        DirNone,
        DirUp,
        DirDown
    } cal_dir_e;

    // Signed code spanning -cal_bits..+cal_bits.
    function automatic int unsigned trim_width(input int unsigned cal_bits);
        return unsigned'($clog2(cal_bits + 1)) + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return unsigned'($clog2(n + 1));
    endfunction

endpackage

// File: rtl/comp_cal_therm.sv
// comp_cal_therm: signed trim code to thermometer trim-capacitor decode.
//
// A positive code switches in that many unit caps on the P side, a negative code the same
// number on the N side; zero leaves both sides empty. Purely combinational; the parent
// registers the outputs.
//
// Ports:
//   trim  in   signed trim code, -CAL_BITS..+CAL_BITS
//   calp  out  thermometer bits, P side (low |trim| bits set when trim > 0)
//   caln  out  thermometer bits, N side (low |trim| bits set when trim < 0)
module comp_cal_therm
    import comp_cal_pkg::*;
#(
    parameter int unsigned CAL_BITS = 4
) (
    input  logic signed [trim_width(CAL_BITS)-1:0] trim,
    output logic        [CAL_BITS-1:0]             calp,
    output logic        [CAL_BITS-1:0]             caln
);

    localparam int unsigned TW = trim_width(CAL_BITS);

    logic          neg;
    logic [TW-1:0] mag;

    always_comb begin
        neg  = trim[TW-1];
        mag  = neg ? -trim : trim;
        calp = '0;
        caln = '0;
        for (int i = 0; i < int'(CAL_BITS); i++) begin
            calp[i] = !neg && (i < int'(mag));
            caln[i] = neg && (i < int'(mag));
        end
    end

endmodule

// File: rtl/comp_offset_cal.sv
// comp_offset_cal: foreground offset-calibration controller for the SAR ADC dynamic comparator.
//
// With the comparator inputs shorted, the block searches a signed trim code one unit per
// step. Each step settles for SETTLE_CYC cycles, collects NSAMP valid decisions, and moves
// the code towards the point where the comparator splits its decisions evenly. It stops on
// an even split, on a change of search direction, at the +/-CAL_BITS limit (SAT), or when
// NSAMP invalid decisions (OUTP == OUTN) accumulate within one step (ERR).
//
// Optional feature: define COMP_CAL_OVERRIDE_EN to add the man_en/man_trim manual trim
// override. Without it the trim code changes only through calibration.
//
// Ports:
//   clk          in   block clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle calibration request, honoured only in idle
//   cmp_rdy      in   comparator decision valid this cycle
//   outp, outn   in   comparator outputs
//   man_en       in   (COMP_CAL_OVERRIDE_EN) load man_trim while idle
//   man_trim     in   (COMP_CAL_OVERRIDE_EN) signed manual trim, clamped to +/-CAL_BITS
//   cal_cmp_req  out  requesting comparator strobes (sampling phase only)
//   calp, caln   out  registered thermometer trim bits, P and N side
//   trim         out  signed current trim code
//   busy         out  calibration in progress
//   done         out  one-cycle end-of-calibration pulse
//   sat          out  sticky: search hit the trim limit
//   err          out  sticky: aborted on invalid decisions
module comp_offset_cal
    import comp_cal_pkg::*;
#(
    parameter int unsigned CAL_BITS   = 4,
    parameter int unsigned NSAMP      = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   cmp_rdy,
    input  logic                                   outp,
    input  logic                                   outn,
`ifdef COMP_CAL_OVERRIDE_EN
    input  logic                                   man_en,
    input  logic signed [trim_width(CAL_BITS)-1:0] man_trim,
`endif
    output logic                                   cal_cmp_req,
    output logic        [CAL_BITS-1:0]             calp,
    output logic        [CAL_BITS-1:0]             caln,
    output logic signed [trim_width(CAL_BITS)-1:0] trim,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   sat,
    output logic                                   err
);

    localparam int unsigned TW = trim_width(CAL_BITS);
    localparam int unsigned CW = cnt_width(NSAMP);
    localparam int unsigned SW = cnt_width(SETTLE_CYC);

    localparam logic signed [TW-1:0] TrimMax    = TW'(CAL_BITS);
    localparam logic signed [TW-1:0] TrimMin    = -TrimMax;
    localparam logic signed [TW-1:0] TrimOne    = TW'(1);
    localparam logic        [CW-1:0] Half       = CW'(NSAMP / 2);
    localparam logic        [CW-1:0] LastCnt    = CW'(NSAMP - 1);
    localparam logic        [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);

    cal_state_e state_q;
    cal_dir_e   prev_dir_q;
    cal_dir_e   dir_now;

    logic [CW-1:0] valid_q;
    logic [CW-1:0] ones_q;
    logic [CW-1:0] inv_q;
    logic [SW-1:0] settle_q;

    logic signed [TW-1:0]       trim_q;
    logic signed [TW-1:0]       trim_d;
    logic        [CAL_BITS-1:0] calp_q;
    logic        [CAL_BITS-1:0] caln_q;
    logic        [CAL_BITS-1:0] calp_d;
    logic        [CAL_BITS-1:0] caln_d;

    logic req_q;
    logic busy_q;
    logic done_q;
    logic sat_q;
    logic err_q;

    logic man_hold;
    logic start_ok;
    logic dec_valid;
    logic inv_abort;
    logic reversal;
    logic at_limit;
    logic step_ok;
    logic sat_hit;

`ifdef COMP_CAL_OVERRIDE_EN
    // Manual override only while idle; it also masks start.
    assign man_hold = (state_q == StIdle) && man_en;
`else
    assign man_hold = 1'b0;
`endif

    assign start_ok  = (state_q == StIdle) && start && !man_hold;
    assign dec_valid = outp ^ outn;
    assign inv_abort = (state_q == StSample) && cmp_rdy && !dec_valid && (inv_q == LastCnt);

    // Step decision from the finished sampling window; only consumed in StDecide.
    always_comb begin
        dir_now = DirNone;
        if (ones_q > Half) begin
            dir_now = DirDown;
        end else if (ones_q < Half) begin
            dir_now = DirUp;
        end
    end

    // A direction change means the zero crossing lies between the last two codes; keep the
    // code that was measured last rather than stepping back.
    assign reversal = (dir_now != DirNone) && (prev_dir_q != DirNone) && (dir_now != prev_dir_q);
    assign at_limit = ((dir_now == DirUp) && (trim_q == TrimMax)) ||
                      ((dir_now == DirDown) && (trim_q == TrimMin));
    assign step_ok  = (dir_now != DirNone) && !reversal && !at_limit;
    assign sat_hit  = (dir_now != DirNone) && !reversal && at_limit;

    // Next trim code, computed combinationally so the thermometer bits can be registered on
    // the same edge as the code itself.
    always_comb begin
        trim_d = trim_q;
        if (start_ok || inv_abort) begin
            trim_d = '0;
        end else if ((state_q == StDecide) && step_ok) begin
            trim_d = (dir_now == DirUp) ? trim_q + TrimOne : trim_q - TrimOne;
        end
`ifdef COMP_CAL_OVERRIDE_EN
        else if (man_hold) begin
            if (man_trim > TrimMax) begin
                trim_d = TrimMax;
            end else if (man_trim < TrimMin) begin
                trim_d = TrimMin;
            end else begin
                trim_d = man_trim;
            end
        end
`endif
    end

    comp_cal_therm #(
        .CAL_BITS (CAL_BITS)
    ) u_therm (
        .trim (trim_d),
        .calp (calp_d),
        .caln (caln_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            prev_dir_q <= DirNone;
            valid_q    <= '0;
            ones_q     <= '0;
            inv_q      <= '0;
            settle_q   <= '0;
            trim_q     <= '0;
            calp_q     <= '0;
            caln_q     <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            trim_q <= trim_d;
            calp_q <= calp_d;
            caln_q <= caln_d;
            done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        sat_q      <= 1'b0;
                        err_q      <= 1'b0;
                        valid_q    <= '0;
                        ones_q     <= '0;
                        inv_q      <= '0;
                        settle_q   <= '0;
                        prev_dir_q <= DirNone;
                        busy_q     <= 1'b1;
                        state_q    <= StSettle;
                    end
                end

                StSettle: begin
                    if (settle_q == SettleLast) begin
                        settle_q <= '0;
                        req_q    <= 1'b1;
                        state_q  <= StSample;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end

                StSample: begin
                    if (cmp_rdy) begin
                        if (dec_valid) begin
                            valid_q <= valid_q + 1'b1;
                            ones_q  <= ones_q + CW'(outp);
                            if (valid_q == LastCnt) begin
                                req_q   <= 1'b0;
                                state_q <= StDecide;
                            end
                        end else begin
                            inv_q <= inv_q + 1'b1;
                            if (inv_abort) begin
                                err_q   <= 1'b1;
                                req_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StFinish;
                            end
                        end
                    end
                end

                StDecide: begin
                    if (step_ok) begin
                        prev_dir_q <= dir_now;
                        valid_q    <= '0;
                        ones_q     <= '0;
                        inv_q      <= '0;
                        state_q    <= StSettle;
                    end else begin
                        if (sat_hit) begin
                            sat_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end
                end

                StFinish: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cal_cmp_req = req_q;
    assign calp        = calp_q;
    assign caln        = caln_q;
    assign trim        = trim_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sat         = sat_q;
    assign err         = err_q;

endmodule

// File: tb/tb_comp_offset_cal.sv
// Directed bench for comp_offset_cal (CAL_BITS=4, NSAMP=16, SETTLE_CYC=4). A behavioural
// comparator offset model answers the strobes; expected per-step trim codes and final results
// are queued before each run and popped as the DUT enters sampling or pulses done.
module tb_comp_offset_cal;

    localparam int unsigned CAL_BITS   = 4;
    localparam int unsigned NSAMP      = 16;
    localparam int unsigned SETTLE_CYC = 4;

    localparam int M_OFFSET = 0;  // ones while trim > -2, even split at -2
    localparam int M_STUCK  = 1;  // outp stuck high
    localparam int M_REV    = 2;  // mostly zeros at 0, mostly ones at +1
    localparam int M_INV    = 3;  // outp == outn always
    localparam int M_INTER  = 4;  // 15 invalids interleaved with an even split
    localparam int M_BAL    = 5;  // even split at every code

    typedef struct {
        logic signed [3:0] trim;
        logic        [3:0] calp;
        logic        [3:0] caln;
        logic              sat;
        logic              err;
    } fin_t;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              start   = 1'b0;
    logic              cmp_rdy = 1'b0;
    logic              outp    = 1'b0;
    logic              outn    = 1'b0;
    logic              cal_cmp_req;
    logic        [3:0] calp;
    logic        [3:0] caln;
    logic signed [3:0] trim;
    logic              busy;
    logic              done;
    logic              sat;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic signed [3:0] step_q[$];
    fin_t              fin_q[$];

    always #5 clk = ~clk;

    comp_offset_cal #(
        .CAL_BITS   (CAL_BITS),
        .NSAMP      (NSAMP),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmp_rdy     (cmp_rdy),
        .outp        (outp),
        .outn        (outn),
`ifdef COMP_CAL_OVERRIDE_EN
        .man_en      (1'b0),
        .man_trim    (4'sd0),
`endif
        .cal_cmp_req (cal_cmp_req),
        .calp        (calp),
        .caln        (caln),
        .trim        (trim),
        .busy        (busy),
        .done        (done),
        .sat         (sat),
        .err         (err)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] therm_exp(input int n);
        case (n)
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0011;
            3:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] exp_p(input logic signed [3:0] t);
        int ti = t;
        return therm_exp(ti > 0 ? ti : 0);
    endfunction

    function automatic logic [3:0] exp_n(input logic signed [3:0] t);
        int ti = t;
        return therm_exp(ti < 0 ? -ti : 0);
    endfunction

    // Comparator model: v/iv are valid/invalid decisions already given in this step.
    task automatic model(input int mode, input logic signed [3:0] t, input int v, input int iv,
                         output logic op, output logic on);
        int ti = t;
        op = 1'b1;
        case (mode)
            M_OFFSET: op = (ti > -2) ? 1'b1 : logic'(v % 2);
            M_STUCK:  op = 1'b1;
            M_REV:    op = (ti == 0) ? logic'(v < 4) : logic'(v < 12);
            M_INV:    op = 1'b1;
            default:  op = logic'(v % 2);
        endcase
        on = ~op;
        if (mode == M_INV || (mode == M_INTER && iv < v && iv < 15)) begin
            op = 1'b0;
            on = 1'b0;
            if (mode == M_INV) begin
                op = 1'b1;
                on = 1'b1;
            end
        end
    endtask

    task automatic pulse(input logic p, input logic n);
        outp    = p;
        outn    = n;
        cmp_rdy = 1'b1;
        @(negedge clk);
        cmp_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int c = 0;
        while (!cal_cmp_req && c < 100) begin
            @(negedge clk);
            c++;
        end
        check(tag, cal_cmp_req, 1);
    endtask

    // One full calibration. perturb adds stray cmp_rdy pulses outside sampling and start
    // pulses while busy, neither of which may change the outcome.
    task automatic run_cal(input int mode, input bit perturb);
        int   v = 0, iv = 0, cyc = 0, fall_cyc = -1;
        bit   req_prev = 1'b0, fin = 1'b0;
        logic op, on;
        logic signed [3:0] es;
        fin_t ef;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!fin && cyc < 3000) begin
            if (done) begin
                cmp_rdy = 1'b0;
                start   = 1'b0;
                fin     = 1'b1;
                check("steps_left", step_q.size(), 0);
                check("final_expected", fin_q.size(), 1);
                if (fin_q.size() > 0) begin
                    ef = fin_q.pop_front();
                    check("final_trim", trim, ef.trim);
                    check("final_calp", calp, ef.calp);
                    check("final_caln", caln, ef.caln);
                    check("final_sat", sat, ef.sat);
                    check("final_err", err, ef.err);
                    check("final_busy", busy, 0);
                end
            end else begin
                if (cal_cmp_req && !req_prev) begin
                    if (fall_cyc < 0) check("settle_first", cyc, SETTLE_CYC);
                    else              check("settle_step", cyc - fall_cyc, SETTLE_CYC + 1);
                    check("step_busy", busy, 1);
                    check("step_expected", step_q.size() > 0, 1);
                    if (step_q.size() > 0) begin
                        es = step_q.pop_front();
                        check("step_trim", trim, es);
                        check("step_calp", calp, exp_p(es));
                        check("step_caln", caln, exp_n(es));
                    end
                    v  = 0;
                    iv = 0;
                end
                if (!cal_cmp_req && req_prev) begin
                    check("step_samples", v, NSAMP);
                    fall_cyc = cyc;
                end
                if (cmp_rdy) begin
                    cmp_rdy = 1'b0;
                end else if (cal_cmp_req) begin
                    model(mode, trim, v, iv, op, on);
                    outp    = op;
                    outn    = on;
                    cmp_rdy = 1'b1;
                    if (op != on) v++;
                    else          iv++;
                end else if (perturb && busy) begin
                    outp    = 1'b1;
                    outn    = 1'b0;
                    cmp_rdy = 1'b1;
                end
                start = perturb && busy && (cyc % 5 == 0);
            end
            req_prev = cal_cmp_req;
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        cmp_rdy = 1'b0;
        check("finished", fin, 1);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #2;
        check("rst_req", cal_cmp_req, 0);
        check("rst_calp", calp, 0);
        check("rst_caln", caln, 0);
        check("rst_trim", trim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-sample after one trim step
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req("midrst_req0");
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0);
        wait_req("midrst_req1");
        check("midrst_trim_pre", trim, -1);
        check("midrst_caln_pre", caln, 4'b0001);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", cal_cmp_req, 0);
        check("midrst_trim", trim, 0);
        check("midrst_caln", caln, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        check("midrst_done_hold", done, 0);
        rst = 1'b0;

        // Offset at -2: 0, -1, -2, converge
        step_q = '{4'sd0, -4'sd1, -4'sd2};
        fin_q.push_back('{trim: -4'sd2, calp: 4'b0000, caln: 4'b0011, sat: 1'b0, err: 1'b0});
        run_cal(M_OFFSET, 1'b0);

        // Stuck high: walks to -4, then saturates
        step_q = '{4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4};
        fin_q.push_back('{trim: -4'sd4, calp: 4'b0000, caln: 4'b1111, sat: 1'b1, err: 1'b0});
        run_cal(M_STUCK, 1'b0);

        // Reversal between 0 and +1 keeps +1; sat cleared by start
        step_q = '{4'sd0, 4'sd1};
        fin_q.push_back('{trim: 4'sd1, calp: 4'b0001, caln: 4'b0000, sat: 1'b0, err: 1'b0});
        run_cal(M_REV, 1'b0);

        // 16 invalid decisions abort with err
        step_q = '{4'sd0};
        fin_q.push_back('{trim: 4'sd0, calp: 4'b0000, caln: 4'b0000, sat: 1'b0, err: 1'b1});
        run_cal(M_INV, 1'b0);

        // 15 interleaved invalids do not abort; err cleared by start
        step_q = '{4'sd0};
        fin_q.push_back('{trim: 4'sd0, calp: 4'b0000, caln: 4'b0000, sat: 1'b0, err: 1'b0});
        run_cal(M_INTER, 1'b0);

        // Stray cmp_rdy during settle and start while busy are ignored
        step_q = '{4'sd0};
        fin_q.push_back('{trim: 4'sd0, calp: 4'b0000, caln: 4'b0000, sat: 1'b0, err: 1'b0});
        run_cal(M_BAL, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
